// File: rtl/reg_wb_arbiter_if.sv
// Bus bundle between the writeback sources, the decoder and the register-file write port.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; ready may depend on valid combinationally, valid never depends on ready.
interface reg_wb_arbiter_if;
  logic        WB_VALID;
  logic [4:0]  WB_ADDR;
  logic [31:0] WB_DATA;
  logic        WB_READY;
  logic        MD_VALID;
  logic [31:0] MD_DATA;
  logic        MD_READY;
  logic        ISSUE_VALID;
  logic [4:0]  ISSUE_ADDR;
  logic        ISSUE_READY;
  logic [4:0]  RS1_ADDR;
  logic [4:0]  RS2_ADDR;
  logic [4:0]  RD_ADDR;
  logic        HAZARD;
  logic        RF_WRITE;
  logic [4:0]  RF_INADDRESS;
  logic [31:0] RF_IN;
  logic [1:0]  dbg_state;
  logic [31:0] dbg_busy;

  modport master (
    output WB_VALID, WB_ADDR, WB_DATA, MD_VALID, MD_DATA,
    output ISSUE_VALID, ISSUE_ADDR, RS1_ADDR, RS2_ADDR, RD_ADDR,
    input  WB_READY, MD_READY, ISSUE_READY, HAZARD,
    input  RF_WRITE, RF_INADDRESS, RF_IN, dbg_state, dbg_busy
  );

  modport slave (
    input  WB_VALID, WB_ADDR, WB_DATA, MD_VALID, MD_DATA,
    input  ISSUE_VALID, ISSUE_ADDR, RS1_ADDR, RS2_ADDR, RD_ADDR,
    output WB_READY, MD_READY, ISSUE_READY, HAZARD,
    output RF_WRITE, RF_INADDRESS, RF_IN, dbg_state, dbg_busy
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Shares the register-file write port between the WB stage and the MUL/DIV unit,
// with a starvation guard and a busy scoreboard for outstanding MUL/DIV destinations.
module reg_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic             CLOCK,
  input logic             RESET,
  reg_wb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

  state_t      state, state_nxt;
  logic [3:0]  starve_cnt;
  logic [4:0]  md_dest;
  logic [31:0] busy, busy_nxt;
  logic        md_grant, wb_grant, issue_acc;
  logic        md_ready, wb_ready, issue_ready;
  logic        rf_write;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (issue_acc) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (md_grant)
          state_nxt = issue_acc ? ST_WAIT : ST_IDLE;
        else if (bus.MD_VALID && bus.WB_VALID && starve_cnt == STARVE_LAST)
          state_nxt = ST_FORCE;
      end
      ST_FORCE: if (md_grant) state_nxt = issue_acc ? ST_WAIT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // A result arriving in IDLE (stale op killed by reset) is acknowledged but never written.
  always_comb begin
    wb_ready    = !(bus.MD_VALID && state == ST_FORCE);
    md_grant    = bus.MD_VALID && (state != ST_IDLE) &&
                  (!bus.WB_VALID || state == ST_FORCE);
    md_ready    = bus.MD_VALID &&
                  (state == ST_IDLE || !bus.WB_VALID || state == ST_FORCE);
    wb_grant    = bus.WB_VALID && wb_ready;
    issue_ready = (state == ST_IDLE) || md_grant;
    issue_acc   = bus.ISSUE_VALID && issue_ready;
  end

  // The set is applied after the clear so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    if (md_grant) busy_nxt[md_dest] = 1'b0;
    if (issue_acc && bus.ISSUE_ADDR != 5'd0) busy_nxt[bus.ISSUE_ADDR] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      starve_cnt <= 4'd0;
      md_dest    <= 5'd0;
      busy       <= 32'd0;
      rf_write   <= 1'b0;
      rf_addr    <= 5'd0;
      rf_data    <= 32'd0;
    end else begin
      busy <= busy_nxt;
      if (issue_acc) md_dest <= bus.ISSUE_ADDR;

      if (!bus.MD_VALID || md_grant)
        starve_cnt <= 4'd0;
      else if (!md_ready && starve_cnt != 4'hF)
        starve_cnt <= starve_cnt + 4'd1;

      if (wb_grant) begin
        rf_write <= (bus.WB_ADDR != 5'd0);
        rf_addr  <= bus.WB_ADDR;
        rf_data  <= bus.WB_DATA;
      end else if (md_grant) begin
        rf_write <= (md_dest != 5'd0);
        rf_addr  <= md_dest;
        rf_data  <= bus.MD_DATA;
      end else begin
        rf_write <= 1'b0;
      end
    end
  end

  assign bus.WB_READY     = wb_ready;
  assign bus.MD_READY     = md_ready;
  assign bus.ISSUE_READY  = issue_ready;
  assign bus.HAZARD       = busy[bus.RS1_ADDR] | busy[bus.RS2_ADDR] | busy[bus.RD_ADDR];
  assign bus.RF_WRITE     = rf_write;
  assign bus.RF_INADDRESS = rf_addr;
  assign bus.RF_IN        = rf_data;
  assign bus.dbg_state    = state;
  assign bus.dbg_busy     = busy;

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Sequences and shares the single register-file write port between two writeback sources: the in-order pipeline WB stage and the multi-cycle MUL/DIV unit.
- Keeps a per-register scoreboard of outstanding MUL/DIV destinations and flags decode-stage RAW/WAW hazards.
- Sits between WB/MUL-DIV and the reg_file write port, driving its IN, INADDRESS and WRITE inputs.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles MD_VALID may lose arbitration before MD is forced to win; legal range 1..15.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  synchronous reset, active high.
- WB_VALID  in  1  pipeline writeback request.
- WB_ADDR  in  5  pipeline destination register.
- WB_DATA  in  32  pipeline writeback data.
- WB_READY  out  1  pipeline request accepted this cycle.
- MD_VALID  in  1  MUL/DIV result request.
- MD_DATA  in  32  MUL/DIV result.
- MD_READY  out  1  MUL/DIV result accepted this cycle.
- ISSUE_VALID  in  1  decode issues a MUL/DIV op.
- ISSUE_ADDR  in  5  destination of the issued op.
- ISSUE_READY  out  1  issue accepted this cycle.
- RS1_ADDR, RS2_ADDR, RD_ADDR  in  5 each  decode-stage operand and destination addresses.
- HAZARD  out  1  decode must stall.
- RF_WRITE  out  1  register-file write enable (registered).
- RF_INADDRESS  out  5  register-file write address (registered).
- RF_IN  out  32  register-file write data (registered).

Behaviour:
- Clocking and reset:
  - Single clock, CLOCK.
  - RESET is synchronous and active high.
  - On reset: RF_WRITE=0, RF_INADDRESS=0, RF_IN=0, starve counter=0, busy[31:0]=0, md_dest=0, FSM=IDLE.
  - Reset has priority over every concurrent event and aborts any outstanding op; a late MD_VALID after reset is accepted and discarded (no write).
- FSM states:
  - IDLE: no MUL/DIV op outstanding.
  - WAIT: one op outstanding; its destination is held in md_dest.
  - FORCE: MD has starved; it wins the next grant.
- FSM transitions:
  - IDLE->WAIT: on an accepted issue.
  - WAIT->FORCE: when MD_VALID && WB_VALID && counter==STARVE_LIMIT-1.
  - WAIT/FORCE->IDLE: on an MD grant, unless a same-cycle issue is accepted, in which case the next state is WAIT.
- Issue handshake:
  - ISSUE_READY = (state==IDLE) || MD grant this cycle. Only one op is outstanding at a time.
  - An accepted issue latches md_dest=ISSUE_ADDR and sets busy[ISSUE_ADDR] if ISSUE_ADDR!=0.
- Arbitration (combinational ready):
  - MD may be granted only in WAIT/FORCE, with MD_VALID.
  - MD_READY = MD_VALID && (!WB_VALID || state==FORCE).
  - WB_READY = !(MD_VALID && state==FORCE); WB has priority otherwise.
  - MD_VALID in IDLE outside the post-reset case is a protocol error: MD_READY=1, no write.
- Starve counter: 4-bit.
  - Increments when MD_VALID and MD loses.
  - Clears on an MD grant or when MD_VALID=0.
  - Saturates.
- Write port (1-cycle latency from grant):
  - RF_WRITE <= grant && dest!=0.
  - RF_INADDRESS/RF_IN take the winner's address/data; MD uses md_dest.
  - Writes to x0 are handshaken but RF_WRITE stays 0.
  - With no grant, RF_WRITE<=0 and address/data hold their value.
- Scoreboard:
  - busy[md_dest] clears on the MD grant.
  - If the same register is cleared and set in the same cycle, set wins.
  - busy[0] is always 0.
- Hazard:
  - HAZARD = busy[RS1_ADDR] | busy[RS2_ADDR] | busy[RD_ADDR], combinational.
  - The decoder holds ISSUE_VALID low while HAZARD=1; a WB write to a busy register never occurs.

Test Plan:
- Reset, then WB_VALID=1, WB_ADDR=5, WB_DATA=0xDEADBEEF -> WB_READY=1; next cycle RF_WRITE=1, RF_INADDRESS=5, RF_IN=0xDEADBEEF.
- Issue ISSUE_ADDR=7 -> ISSUE_READY=1, busy[7]=1, HAZARD=1 for RS1_ADDR=7 and for RD_ADDR=7; second issue -> ISSUE_READY=0; MD_VALID, MD_DATA=0x12 with WB idle -> write r7=0x12 and HAZARD drops the cycle after the grant.
- MD_VALID and WB_VALID held high, STARVE_LIMIT=4 -> WB wins 4 cycles, then MD wins cycle 5 with WB_READY=0; counter clears.
- MD grant and a new issue to the same r7 in one cycle -> r7 written, busy[7] stays 1, state stays WAIT.
- WB_ADDR=0 and issue to x0 with MD result -> both handshakes complete, RF_WRITE never asserted, HAZARD=0.
- RESET asserted while in WAIT with busy[9]=1 -> next cycle busy=0, FSM IDLE, RF_WRITE=0, ISSUE_READY=1.
